// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-fetch (I) and load/store (D) requesters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;   // 1 = D port owns the access
    logic              last_q, last_d;
    logic              pick;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, i_rdata_d, d_rdata_d;
    logic              re_d, we_d, i_ack_d, d_ack_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pick      = 1'b0;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        re_d      = mem_re;
        we_d      = mem_we;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that did not win last time goes next.
                    pick    = (i_req && d_req) ? ~last_q : d_req;
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? d_addr : i_addr;
                    if (pick) begin
                        wdata_d = d_wdata;
                    end
                    re_d    = ~(pick & d_we);
                    we_d    = pick & d_we;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (mem_re) begin
                        if (grant_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    i_ack_d = ~grant_q;
                    d_ack_d = grant_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_re    <= re_d;
            mem_we    <= we_d;
            i_ack     <= i_ack_d;
            d_ack     <= d_ack_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected completions,
// a negedge monitor checks memory-pin activity and pops on every ack.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_re, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic        i_req_1, d_req_1, d_we_1;
    logic [31:0] i_addr_1, d_addr_1, d_wdata_1, mem_rdata_1;
    logic        i_ack_1, d_ack_1, mem_re_1, mem_we_1, busy_1;
    logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_ack(i_ack_1), .i_rdata(i_rdata_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_ack(d_ack_1), .d_rdata(d_rdata_1),
        .mem_addr(mem_addr_1), .mem_re(mem_re_1), .mem_we(mem_we_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
    );

    assign mem_rdata_1 = mem_addr_1 ^ 32'h5A5A0000;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void checkb(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event expected completion (t=%0t)", name, $time);
    endfunction

    // Memory contents: an address-derived pattern unless explicitly written.
    logic [31:0] tbmem  [logic [31:0]];
    logic [31:0] refmem [logic [31:0]];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : init_word(a);
    endfunction

    always @(negedge clk) begin
        if (mem_we) tbmem[mem_addr] = mem_wdata;
        mem_rdata <= mem_re ? (tbmem.exists(mem_addr) ? tbmem[mem_addr] : init_word(mem_addr))
                            : 32'hBAD0BAD0;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] d_last_load = 32'h0;

    function automatic void push_i(logic [31:0] a);
        exp_t e;
        e.addr = a; e.we = 1'b0; e.wdata = 32'h0; e.rdata = ref_rd(a);
        iq.push_back(e);
    endfunction

    function automatic void push_d(logic [31:0] a, logic we, logic [31:0] wd);
        exp_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        if (we) begin
            refmem[a] = wd;
            e.rdata   = d_last_load;
        end else begin
            e.rdata     = ref_rd(a);
            d_last_load = e.rdata;
        end
        dq.push_back(e);
    endfunction

    // Monitor
    logic        in_acc = 1'b0;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;
    int          acc_len = 0;
    logic        prev_i_ack = 1'b0, prev_d_ack = 1'b0;
    logic [31:0] i_hold = 32'h0, d_hold = 32'h0;
    int          d_ack_cnt = 0;
    bit          ack_order[$];
    exp_t        me;

    always @(negedge clk) begin
        if (!reset) begin
            in_acc = 1'b0; prev_i_ack = 1'b0; prev_d_ack = 1'b0;
            i_hold = 32'h0; d_hold = 32'h0;
        end else begin
            checkb("strobe_excl", mem_re & mem_we, 1'b0);
            checkb("ack_excl", i_ack & d_ack, 1'b0);
            if (mem_re || mem_we || i_ack || d_ack) checkb("busy_active", busy, 1'b1);
            if (mem_re || mem_we) begin
                if (!in_acc) begin
                    in_acc = 1'b1; acc_addr = mem_addr; acc_we = mem_we;
                    acc_wdata = mem_wdata; acc_len = 1;
                end else begin
                    acc_len++;
                    check("addr_hold", mem_addr, acc_addr);
                    checkb("we_hold", mem_we, acc_we);
                    if (acc_we) check("wdata_hold", mem_wdata, acc_wdata);
                end
            end else begin
                in_acc = 1'b0;
            end
            if (i_ack) begin
                ack_order.push_back(1'b0);
                checkb("i_ack_pulse", prev_i_ack, 1'b0);
                if (iq.size() == 0) fail_now("i_ack_unexpected");
                else begin
                    me = iq.pop_front();
                    check("i_acc_addr", acc_addr, me.addr);
                    checkb("i_acc_we", acc_we, 1'b0);
                    check("i_acc_len", acc_len, LAT);
                    check("i_rdata", i_rdata, me.rdata);
                    i_hold = me.rdata;
                end
            end else begin
                check("i_rdata_hold", i_rdata, i_hold);
            end
            if (d_ack) begin
                d_ack_cnt++;
                ack_order.push_back(1'b1);
                checkb("d_ack_pulse", prev_d_ack, 1'b0);
                if (dq.size() == 0) fail_now("d_ack_unexpected");
                else begin
                    me = dq.pop_front();
                    check("d_acc_addr", acc_addr, me.addr);
                    checkb("d_acc_we", acc_we, me.we);
                    if (me.we) check("d_acc_wdata", acc_wdata, me.wdata);
                    check("d_acc_len", acc_len, LAT);
                    check("d_rdata", d_rdata, me.rdata);
                    d_hold = me.rdata;
                end
            end else begin
                check("d_rdata_hold", d_rdata, d_hold);
            end
            prev_i_ack = i_ack;
            prev_d_ack = d_ack;
        end
    end

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic full_reset();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checkb("rst_i_ack", i_ack, 1'b0);   checkb("rst_d_ack", d_ack, 1'b0);
        check("rst_i_rdata", i_rdata, 32'h0); check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0); check("rst_mem_wdata", mem_wdata, 32'h0);
        checkb("rst_mem_re", mem_re, 1'b0); checkb("rst_mem_we", mem_we, 1'b0);
        checkb("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        d_last_load = 32'h0;
        idle(1);
    endtask

    task automatic run_i(int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            int w;
            logic [31:0] a;
            gap = int'($urandom_range(0, 3));
            a   = 32'(4 * $urandom_range(0, 63));
            if (gap > 0) begin i_req = 1'b0; idle(gap); end
            i_addr = a; i_req = 1'b1; push_i(a);
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!i_ack && w < 60);
            if (!i_ack) fail_now("i_rand_timeout");
            idle(1);
        end
        i_req = 1'b0;
    endtask

    task automatic run_d(int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            int w;
            logic [31:0] a, wd;
            logic we;
            gap = int'($urandom_range(0, 3));
            a   = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (gap > 0) begin d_req = 1'b0; idle(gap); end
            d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; push_d(a, we, wd);
            w = 0;
            do begin @(posedge clk); #1; w++; end while (!d_ack && w < 60);
            if (!d_ack) fail_now("d_rand_timeout");
            idle(1);
        end
        d_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, ic, dc, last_cyc, prev_cyc, nacks, busy_lo, d_before;
        i_req_1 = 1'b0; d_req_1 = 1'b0; d_we_1 = 1'b0;
        i_addr_1 = 32'h0; d_addr_1 = 32'h0; d_wdata_1 = 32'h0;
        #1 reset = 1'b0;
        full_reset();

        // Single fetch on the MEM_LAT=1 instance
        i_addr_1 = 32'h300; i_req_1 = 1'b1;
        idle(1);
        checkb("l1_re", mem_re_1, 1'b1); checkb("l1_ack_early", i_ack_1, 1'b0);
        idle(1);
        checkb("l1_ack", i_ack_1, 1'b1); checkb("l1_re_off", mem_re_1, 1'b0);
        check("l1_rdata", i_rdata_1, 32'h300 ^ 32'h5A5A0000);
        i_req_1 = 1'b0;
        idle(1);
        checkb("l1_ack_clr", i_ack_1, 1'b0);

        // Directed fetch
        tbmem[32'h40] = 32'hDEADBEEF; refmem[32'h40] = 32'hDEADBEEF;
        i_addr = 32'h40; i_req = 1'b1; push_i(32'h40);
        idle(1);
        checkb("f_re1", mem_re, 1'b1); check("f_addr1", mem_addr, 32'h40); checkb("f_busy", busy, 1'b1);
        i_addr = 32'h44;
        idle(1);
        checkb("f_re2", mem_re, 1'b1); check("f_addr2", mem_addr, 32'h40); checkb("f_ack_early", i_ack, 1'b0);
        idle(1);
        checkb("f_ack", i_ack, 1'b1); checkb("f_re_off", mem_re, 1'b0); check("f_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
        idle(1);
        checkb("f_ack_clr", i_ack, 1'b0); check("f_rdata_held", i_rdata, 32'hDEADBEEF); checkb("f_idle", busy, 1'b0);

        // Directed store
        d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_req = 1'b1;
        push_d(32'h80, 1'b1, 32'h12345678);
        idle(1);
        checkb("s_we1", mem_we, 1'b1); checkb("s_re1", mem_re, 1'b0);
        check("s_addr", mem_addr, 32'h80); check("s_wdata", mem_wdata, 32'h12345678);
        d_addr = 32'h84; d_wdata = 32'hFFFF0000;
        idle(1);
        checkb("s_we2", mem_we, 1'b1); check("s_wdata2", mem_wdata, 32'h12345678);
        idle(1);
        checkb("s_ack", d_ack, 1'b1); checkb("s_we_off", mem_we, 1'b0); check("s_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        idle(1);
        checkb("s_ack_clr", d_ack, 1'b0);

        // Tie after reset: I, D, I, D
        full_reset();
        ack_order.delete();
        i_addr = 32'h100; d_addr = 32'h1000; d_we = 1'b0;
        push_i(32'h100); push_i(32'h100);
        push_d(32'h1000, 1'b0, 32'h0); push_d(32'h1000, 1'b0, 32'h0);
        i_req = 1'b1; d_req = 1'b1;
        cyc = 0; ic = 0; dc = 0; last_cyc = 0;
        while ((ic < 2 || dc < 2) && cyc < 100) begin
            idle(1); cyc++;
            if (i_ack) begin ic++; last_cyc = cyc; if (ic == 2) i_req = 1'b0; end
            if (d_ack) begin dc++; last_cyc = cyc; if (dc == 2) d_req = 1'b0; end
        end
        @(negedge clk); #1;
        check("tie_acks", ack_order.size(), 4);
        if (ack_order.size() == 4) begin
            checkb("tie_g0", ack_order[0], 1'b0); checkb("tie_g1", ack_order[1], 1'b1);
            checkb("tie_g2", ack_order[2], 1'b0); checkb("tie_g3", ack_order[3], 1'b1);
        end
        check("tie_cycles", last_cyc, 3 * (LAT + 2) + LAT + 1);
        @(posedge clk); #1;

        // Back-to-back fetches with i_req held
        i_addr = 32'h200; push_i(32'h200); push_i(32'h200); push_i(32'h200);
        i_req = 1'b1;
        cyc = 0; nacks = 0; prev_cyc = 0; busy_lo = 0;
        while (nacks < 3 && cyc < 100) begin
            idle(1); cyc++;
            if (nacks >= 1 && !busy) busy_lo++;
            if (i_ack) begin
                if (nacks == 0) check("b2b_first", cyc, LAT + 1);
                else check("b2b_spacing", cyc - prev_cyc, LAT + 2);
                prev_cyc = cyc; nacks++;
                if (nacks == 3) i_req = 1'b0;
            end
        end
        check("b2b_count", nacks, 3);
        check("b2b_busy_lo", busy_lo, 2);
        idle(1);

        // Reset during a load
        d_we = 1'b0; d_addr = 32'h1008; d_req = 1'b1;
        push_d(32'h1008, 1'b0, 32'h0);
        idle(1);
        checkb("ra_re_pre", mem_re, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkb("ra_re", mem_re, 1'b0); checkb("ra_busy", busy, 1'b0);
        checkb("ra_d_ack", d_ack, 1'b0); check("ra_addr", mem_addr, 32'h0);
        @(posedge clk); #3 reset = 1'b1;
        d_before = d_ack_cnt;
        cyc = 0; last_cyc = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1); cyc++;
            if (d_ack) begin last_cyc = cyc; d_req = 1'b0; end
        end
        check("ra_ack_cycle", last_cyc, LAT + 1);
        check("ra_ack_count", d_ack_cnt - d_before, 1);

        // Randomised contention
        fork
            run_i(40);
            run_d(40);
        join
        idle(6);
        check("iq_empty", iq.size(), 0);
        check("dq_empty", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
